// File: rtl/carregador_pkg.sv
`default_nettype none
// ============================================================================
// Module   : carregador_pkg
// Brief    : Shared types, error codes and baud-divider helper for the UART
//            boot loader. CARREGADOR_CHECKSUM_EN adds the CHECK state.
// Revision : 1.0 - initial release
// ============================================================================
package carregador_pkg;

    localparam int OVERSAMPLE = 16;

    localparam logic [1:0] ERRO_NENHUM   = 2'b00;
    localparam logic [1:0] ERRO_QUADRO   = 2'b01;
    localparam logic [1:0] ERRO_TAMANHO  = 2'b10;
    localparam logic [1:0] ERRO_CHECKSUM = 2'b11;

    typedef enum logic [2:0] {
        ESPERA_H = 3'd0,
        ESPERA_L = 3'd1,
        PALAVRA  = 3'd2,
`ifdef CARREGADOR_CHECKSUM_EN
        CHECK    = 3'd3,
`endif
        PRONTO   = 3'd4,
        ERRO     = 3'd5
    } estado_t;

    typedef enum logic [1:0] {
        RX_OCIOSO = 2'd0,
        RX_INICIO = 2'd1,
        RX_DADOS  = 2'd2,
        RX_PARADA = 2'd3
    } rx_estado_t;

    // Clocks per oversample tick, truncated; never below one clock.
    function automatic int calc_div(input int clk_freq, input int baud);
        int d;
        d = clk_freq / (baud * OVERSAMPLE);
        return (d < 1) ? 1 : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/carregador_uart_if.sv
`default_nettype none
// ============================================================================
// Module   : carregador_uart_if
// Brief    : Instruction-memory write port between the boot loader (master)
//            and the instruction memory (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface carregador_uart_if #(
    parameter int ADDR_W = 32
);
    logic              mem_escrita;
    logic [ADDR_W-1:0] mem_endereco;
    logic [31:0]       mem_dado;

    modport master (
        output mem_escrita,
        output mem_endereco,
        output mem_dado
    );

    modport slave (
        input  mem_escrita,
        input  mem_endereco,
        input  mem_dado
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_byte
// Brief    : 8N1 receiver: 2-FF synchronizer, 16x oversample tick divider and
//            receive FSM producing byte_ok / quadro_ruim one-clock pulses.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_byte
    import carregador_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  wire logic       clock,
    input  wire logic       reset_n,
    input  wire logic       rx,
    output logic [7:0]      rx_byte,
    output logic            byte_ok,
    output logic            quadro_ruim
);

    localparam int DIV   = calc_div(CLK_FREQ, BAUD);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(DIV - 1);
    localparam logic [3:0]       MEIO_BIT = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]       FIM_BIT  = 4'(OVERSAMPLE - 1);

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    rx_estado_t       estado_q, estado_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       tick_q, tick_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             byte_ok_q, byte_ok_d;
    logic             quadro_q, quadro_d;
    logic             tick;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            estado_q  <= RX_OCIOSO;
            div_q     <= '0;
            tick_q    <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            byte_ok_q <= 1'b0;
            quadro_q  <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            estado_q  <= estado_d;
            div_q     <= div_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            byte_ok_q <= byte_ok_d;
            quadro_q  <= quadro_d;
        end
    end

    assign tick = (div_q == DIV_MAX);

    always_comb begin
        estado_d  = estado_q;
        div_d     = div_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        byte_ok_d = 1'b0;
        quadro_d  = 1'b0;

        if (estado_q != RX_OCIOSO) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end

        case (estado_q)
            RX_OCIOSO: begin
                // The divider restarts on the edge so every sample lands mid-bit.
                if (rx_prev_q && !rx_sync_q) begin
                    estado_d = RX_INICIO;
                    div_d    = '0;
                    tick_d   = '0;
                end
            end
            RX_INICIO: begin
                if (tick) begin
                    if (tick_q == MEIO_BIT) begin
                        tick_d = '0;
                        bit_d  = '0;
                        estado_d = rx_sync_q ? RX_OCIOSO : RX_DADOS;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            RX_DADOS: begin
                if (tick) begin
                    if (tick_q == FIM_BIT) begin
                        shreg_d = {rx_sync_q, shreg_q[7:1]};
                        tick_d  = '0;
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == 3'd7) begin
                            estado_d = RX_PARADA;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            RX_PARADA: begin
                if (tick) begin
                    if (tick_q == FIM_BIT) begin
                        byte_ok_d = rx_sync_q;
                        quadro_d  = ~rx_sync_q;
                        estado_d  = RX_OCIOSO;
                        tick_d    = '0;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            default: estado_d = RX_OCIOSO;
        endcase
    end

    assign rx_byte     = shreg_q;
    assign byte_ok     = byte_ok_q;
    assign quadro_ruim = quadro_q;

endmodule
`default_nettype wire

// File: rtl/carregador_uart.sv
`default_nettype none
// ============================================================================
// Module   : carregador_uart
// Brief    : UART boot loader: receives [N:16 BE][N words, MSB first] and
//            writes them to instruction memory, holding the CPU until done.
//            CARREGADOR_CHECKSUM_EN appends and verifies an XOR checksum byte.
// Revision : 1.0 - initial release
// ============================================================================
module carregador_uart
    import carregador_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 115200,
    parameter int ADDR_W    = 32,
    parameter int MAX_WORDS = 256
) (
    input  wire logic          clock,
    input  wire logic          reset_n,
    input  wire logic          rx,
    carregador_uart_if.master  mem,
    output logic               carregando,
    output logic               pronto,
    output logic [1:0]         erro,
    output logic               segurar_cpu
);

    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

`ifdef CARREGADOR_CHECKSUM_EN
    localparam estado_t ESTADO_FIM = CHECK;
`else
    localparam estado_t ESTADO_FIM = PRONTO;
`endif

    logic [7:0] rx_byte;
    logic       byte_ok;
    logic       quadro_ruim;

    uart_rx_byte #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_rx (
        .clock       (clock),
        .reset_n     (reset_n),
        .rx          (rx),
        .rx_byte     (rx_byte),
        .byte_ok     (byte_ok),
        .quadro_ruim (quadro_ruim)
    );

    estado_t           estado_q, estado_d;
    logic [1:0]        erro_q, erro_d;
    logic [15:0]       n_q, n_d;
    logic [31:0]       palavra_q, palavra_d;
    logic [1:0]        idx_q, idx_d;
    logic [15:0]       palavras_q, palavras_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              escrita_q, escrita_d;
    logic [ADDR_W-1:0] endereco_q, endereco_d;
    logic [31:0]       dado_q, dado_d;
    logic [15:0]       n_novo;
    logic [31:0]       palavra_nova;
`ifdef CARREGADOR_CHECKSUM_EN
    logic [7:0]        soma_q, soma_d;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            estado_q   <= ESPERA_H;
            erro_q     <= ERRO_NENHUM;
            n_q        <= '0;
            palavra_q  <= '0;
            idx_q      <= '0;
            palavras_q <= '0;
            addr_q     <= '0;
            escrita_q  <= 1'b0;
            endereco_q <= '0;
            dado_q     <= '0;
`ifdef CARREGADOR_CHECKSUM_EN
            soma_q     <= '0;
`endif
        end else begin
            estado_q   <= estado_d;
            erro_q     <= erro_d;
            n_q        <= n_d;
            palavra_q  <= palavra_d;
            idx_q      <= idx_d;
            palavras_q <= palavras_d;
            addr_q     <= addr_d;
            escrita_q  <= escrita_d;
            endereco_q <= endereco_d;
            dado_q     <= dado_d;
`ifdef CARREGADOR_CHECKSUM_EN
            soma_q     <= soma_d;
`endif
        end
    end

    always_comb begin
        estado_d     = estado_q;
        erro_d       = erro_q;
        n_d          = n_q;
        palavra_d    = palavra_q;
        idx_d        = idx_q;
        palavras_d   = palavras_q;
        addr_d       = addr_q;
        escrita_d    = 1'b0;
        endereco_d   = endereco_q;
        dado_d       = dado_q;
        n_novo       = {n_q[15:8], rx_byte};
        palavra_nova = {palavra_q[23:0], rx_byte};
`ifdef CARREGADOR_CHECKSUM_EN
        soma_d       = soma_q;
`endif

        case (estado_q)
            ESPERA_H: begin
                if (quadro_ruim) begin
                    estado_d = ERRO;
                    erro_d   = ERRO_QUADRO;
                end else if (byte_ok) begin
                    n_d      = {rx_byte, 8'h00};
                    estado_d = ESPERA_L;
                end
            end
            ESPERA_L: begin
                if (quadro_ruim) begin
                    estado_d = ERRO;
                    erro_d   = ERRO_QUADRO;
                end else if (byte_ok) begin
                    n_d = n_novo;
                    if (n_novo > MAX_N) begin
                        estado_d = ERRO;
                        erro_d   = ERRO_TAMANHO;
                    end else if (n_novo == 16'd0) begin
                        estado_d = ESTADO_FIM;
                    end else begin
                        estado_d   = PALAVRA;
                        idx_d      = '0;
                        palavras_d = '0;
                    end
                end
            end
            PALAVRA: begin
                if (quadro_ruim) begin
                    estado_d = ERRO;
                    erro_d   = ERRO_QUADRO;
                end else if (byte_ok) begin
                    palavra_d = palavra_nova;
                    idx_d     = idx_q + 1'b1;
                    if (idx_q == 2'd3) begin
                        escrita_d  = 1'b1;
                        dado_d     = palavra_nova;
                        endereco_d = addr_q;
                        addr_d     = addr_q + ADDR_W'(4);
                        palavras_d = palavras_q + 16'd1;
                        if ((palavras_q + 16'd1) == n_q) begin
                            estado_d = ESTADO_FIM;
                        end
                    end
                end
            end
`ifdef CARREGADOR_CHECKSUM_EN
            CHECK: begin
                if (quadro_ruim) begin
                    estado_d = ERRO;
                    erro_d   = ERRO_QUADRO;
                end else if (byte_ok) begin
                    if (rx_byte == soma_q) begin
                        estado_d = PRONTO;
                    end else begin
                        estado_d = ERRO;
                        erro_d   = ERRO_CHECKSUM;
                    end
                end
            end
`endif
            // PRONTO and ERRO are absorbing; only reset leaves them.
            default: ;
        endcase

`ifdef CARREGADOR_CHECKSUM_EN
        if (byte_ok && ((estado_q == ESPERA_H) || (estado_q == ESPERA_L) ||
                        (estado_q == PALAVRA))) begin
            soma_d = soma_q ^ rx_byte;
        end
`endif
    end

    assign mem.mem_escrita  = escrita_q;
    assign mem.mem_endereco = endereco_q;
    assign mem.mem_dado     = dado_q;

    assign carregando  = (estado_q == ESPERA_L) || (estado_q == PALAVRA);
    assign pronto      = (estado_q == PRONTO);
    assign erro        = erro_q;
    assign segurar_cpu = ~pronto;

endmodule
`default_nettype wire

// File: doc/carregador_uart.md
Name: carregador_uart

Overview:
- UART boot loader that receives a program image over a serial RX line and writes it word-by-word into instruction memory.
- Writer end of the instruction-memory interface that the processor's fetch stage reads.
- Holds the processor in reset (via `segurar_cpu`) until the image is complete and valid.
- Sits between the board RX pin and the instruction memory write port.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate; 8N1 framing, LSB first.
- ADDR_W, 32, width of the memory byte address.
- MAX_WORDS, 256, maximum words accepted; must be ≤ 65535.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- rx  in  1  asynchronous serial input; idle high.
- mem_escrita  out  1  one-cycle write strobe to instruction memory.
- mem_endereco  out  ADDR_W  byte address of the write; word aligned.
- mem_dado  out  32  word to write.
- carregando  out  1  high while the header or body is being received.
- pronto  out  1  image complete; sticky until reset.
- erro  out  2  00 none, 01 framing, 10 size, 11 checksum; sticky until reset.
- segurar_cpu  out  1  equals ~pronto; drives the processor reset/hold.

Behaviour:
- Reset (reset_n=0 at a clock edge), to be applied identically mid-load:
  - mem_escrita=0, mem_endereco=0, mem_dado=0.
  - carregando=0, pronto=0, erro=00, segurar_cpu=1.
  - FSM goes to ESPERA_H; the RX sub-block goes to idle; all counters are cleared.
  - A partially received word is discarded.
- Clock and reset are fixed as decided: one clock; reset is synchronous and active-low.
- RX synchronization and baud timing:
  - rx passes through a 2-FF synchronizer before any use.
  - Oversample tick every DIV = CLK_FREQ/(BAUD*16) clocks (integer truncation); 27 at the defaults.
- RX byte reception:
  - A start is detected on a synchronized high-to-low transition.
  - The start bit is re-sampled at tick 8. If high, it is a glitch: return to idle with no byte.
  - Data bits are sampled every 16 ticks from there.
  - The stop bit is sampled at its mid-point. There, byte_ok pulses for 1 clock if stop=1, or quadro_ruim pulses if stop=0.
- Image format, in order:
  - 2-byte word count N, big-endian.
  - N words, each 4 bytes, MSB first.
  - With CARREGADOR_CHECKSUM_EN only: 1 checksum byte.
- FSM states: ESPERA_H, ESPERA_L, PALAVRA, CHECK, PRONTO, ERRO.
  - ESPERA_H: first byte_ok → N[15:8]; go to ESPERA_L.
  - ESPERA_L: byte_ok → N[7:0], then:
    - N > MAX_WORDS: erro=10, go to ERRO.
    - N = 0: go to CHECK if the feature is enabled, else PRONTO.
    - Otherwise: go to PALAVRA.
  - carregando=1 from the first header byte_ok until leaving PALAVRA.
  - PALAVRA:
    - Shift bytes into a 32-bit register.
    - On the 4th byte_ok, mem_escrita pulses the following cycle, with mem_dado = the assembled word and mem_endereco = 4*k, where k is the word index starting at 0.
    - mem_endereco increments by 4 after each write and wraps modulo 2^ADDR_W.
    - After write N, go to CHECK (feature enabled) or PRONTO.
  - PRONTO: pronto=1. Further RX bytes are ignored. No further writes occur.
  - ERRO:
    - Entered on quadro_ruim in any state before PRONTO, with erro=01.
    - Also entered from the size and checksum errors, with their codes.
    - No further writes. pronto stays 0; segurar_cpu stays 1.
    - Only reset exits this state.
  - quadro_ruim in PRONTO is ignored.
  - Simultaneous byte_ok and quadro_ruim cannot occur: they are mutually exclusive by construction.
- Words already written before an error are not rolled back.

Optional Feature:
- Macro: CARREGADOR_CHECKSUM_EN.
- Enabled:
  - A running XOR is taken over every byte after reset, header included.
  - CHECK waits for one more byte_ok. If it equals the running XOR, go to PRONTO; else erro=11 and go to ERRO.
- Disabled:
  - The CHECK state and the XOR register are absent.
  - The last word goes directly to PRONTO.

Decomposition:
- Shared package carregador_pkg contains:
  - FSM state enum.
  - erro codes: ERRO_NENHUM, ERRO_QUADRO, ERRO_TAMANHO, ERRO_CHECKSUM.
  - OVERSAMPLE=16.
  - The DIV computation function.
- One sub-module, uart_rx_byte: synchronizer, tick divider, and 8N1 receive FSM. Outputs are byte[7:0], byte_ok and quadro_ruim.

Test Plan (defaults, DIV=27; bytes sent at exact BAUD):
- Send 00 02 20 08 00 05 01 09 50 20 → exactly two writes: (addr 0x0, data 0x20080005) then (addr 0x4, data 0x01095020). Then pronto=1, segurar_cpu=0, erro=00, carregando=0.
- Send 00 02 then a byte with stop bit 0 → erro=01, zero writes, pronto=0. Any further valid bytes produce no writes.
- Send 00 FF (N=255 ≤ 256), then 01 01 (N=257) after reset → first run proceeds normally; second run gives erro=10 one cycle after the second byte, with no writes.
- Send 00 00 → pronto=1 with no write (feature off). With the feature on, checksum byte 00 → pronto=1; byte 01 → erro=11.
- Hold rx low for 4 oversample ticks only, then high → no byte_ok and no state change. Assert reset_n=0 for 1 cycle after the 2nd word byte, then send a full image → writes start again at addr 0 with correct data.
